// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Word and address widths, the zero word, and the opcodes the predictor decodes.
//   - FSM state encoding.
//   - Immediate extraction helpers for JAL (J-type) and conditional branches (B-type).
package if_fetch_pkg;

    localparam int unsigned AddrLen  = 32;
    localparam int unsigned InstLen  = 32;
    localparam logic [InstLen-1:0] ZeroWord = '0;

    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [0:0] {
        StIdle,
        StWaitMem
    } fetch_state_e;

    // f = inst[31:12]
    function automatic logic [AddrLen-1:0] imm_j(input logic [19:0] f);
        return {{11{f[19]}}, f[19], f[7:0], f[8], f[18:9], 1'b0};
    endfunction

    // hi = inst[31:25], lo = inst[11:7]
    function automatic logic [AddrLen-1:0] imm_b(input logic [6:0] hi, input logic [4:0] lo);
        return {{19{hi[6]}}, hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_bht.sv
// Branch history table: array of 2-bit saturating counters, reset to weakly not-taken.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   en_i               global enable; counters freeze when low
//   lookup_idx_i       index for the prediction lookup
//   lookup_taken_o     MSB of the looked-up counter (1 = predict taken)
//   upd_en_i           update strobe
//   upd_idx_i          index of the counter to update
//   upd_taken_i        resolved direction (1 = increment, 0 = decrement)
// A lookup in the same cycle as an update to the same index returns the pre-update value.
module if_fetch_bht #(
    parameter int unsigned IdxW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [IdxW-1:0] lookup_idx_i,
    output logic            lookup_taken_o,
    input  logic            upd_en_i,
    input  logic [IdxW-1:0] upd_idx_i,
    input  logic            upd_taken_i
);

    localparam int unsigned Entries = 1 << IdxW;

    logic [1:0] cnt_q [Entries];
    logic [1:0] cnt_cur;
    logic [1:0] cnt_upd;

    always_comb begin
        cnt_cur = cnt_q[upd_idx_i];
        cnt_upd = cnt_cur;
        if (upd_taken_i) begin
            if (cnt_cur != 2'b11) cnt_upd = cnt_cur + 2'b01;
        end else begin
            if (cnt_cur != 2'b00) cnt_upd = cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Entries; i++) cnt_q[i] <= 2'b01;
        end else if (en_i && upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_upd;
        end
    end

    assign lookup_taken_o = cnt_q[lookup_idx_i][1];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: holds the PC, fetches 32-bit words from the memory controller,
// predicts the next PC (static JAL decode + BHT for conditional branches) and presents
// if_pc/if_inst/pred/stall to the if/id register.
// Configuration macro: ICACHE_EN -- when defined, a direct-mapped one-word-per-line I-cache
// serves hits in the same cycle; when undefined every instruction goes through memory.
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   rdy_i                             global enable; all state freezes when low
//   if_id_stall_i                     downstream hold
//   failed_i, failed_pc_i             misprediction redirect
//   upd_en_i, upd_pc_i, upd_taken_i   BHT update from EX
//   mem_req_o, mem_addr_o             fetch request (held until mem_done_i)
//   mem_done_i, mem_inst_i            one-cycle response
//   if_pc_o, if_inst_o                presented instruction and its PC
//   pred_jump_or_not_o                1 = predicted next PC is not pc+4
//   if_stall_o                        1 = no valid instruction this cycle
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned IcacheIdxW = 7,
    parameter int unsigned BhtIdxW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rdy_i,
    input  logic               if_id_stall_i,
    input  logic               failed_i,
    input  logic [AddrLen-1:0] failed_pc_i,
    input  logic               upd_en_i,
    input  logic [AddrLen-1:0] upd_pc_i,
    input  logic               upd_taken_i,
    output logic               mem_req_o,
    output logic [AddrLen-1:0] mem_addr_o,
    input  logic               mem_done_i,
    input  logic [InstLen-1:0] mem_inst_i,
    output logic [AddrLen-1:0] if_pc_o,
    output logic [InstLen-1:0] if_inst_o,
    output logic               pred_jump_or_not_o,
    output logic               if_stall_o
);

    fetch_state_e       state_q, state_d;
    logic [AddrLen-1:0] pc_q, pc_d;
    logic [InstLen-1:0] buf_q, buf_d;
    logic               buf_valid_q, buf_valid_d;
    logic               discard_q, discard_d;
    logic               mem_req_q, mem_req_d;
    logic [AddrLen-1:0] mem_addr_q, mem_addr_d;

    logic               hit;
    logic [InstLen-1:0] hit_inst;
    logic               avail;
    logic [InstLen-1:0] cur_inst;
    logic [AddrLen-1:0] next_pc;
    logic               pred;
    logic               bht_taken;

    // ------------------------------------------------------------------ branch predictor
    if_fetch_bht #(
        .IdxW(BhtIdxW)
    ) u_bht (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (rdy_i),
        .lookup_idx_i   (pc_q[BhtIdxW+1:2]),
        .lookup_taken_o (bht_taken),
        .upd_en_i       (upd_en_i),
        .upd_idx_i      (upd_pc_i[BhtIdxW+1:2]),
        .upd_taken_i    (upd_taken_i)
    );

    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc_i[AddrLen-1:BhtIdxW+2], upd_pc_i[1:0]};

    // ------------------------------------------------------------------ instruction cache
`ifdef ICACHE_EN
    localparam int unsigned Lines = 1 << IcacheIdxW;
    localparam int unsigned TagW  = AddrLen - IcacheIdxW - 2;

    logic [Lines-1:0]   ic_valid_q;
    logic [TagW-1:0]    ic_tag_q  [Lines];
    logic [InstLen-1:0] ic_data_q [Lines];
    logic               fill;

    // Fill uses the held request address, so discarded responses still land correctly.
    assign fill     = rdy_i && (state_q == StWaitMem) && mem_done_i;
    assign hit      = ic_valid_q[pc_q[IcacheIdxW+1:2]]
                      && (ic_tag_q[pc_q[IcacheIdxW+1:2]] == pc_q[AddrLen-1:IcacheIdxW+2]);
    assign hit_inst = ic_data_q[pc_q[IcacheIdxW+1:2]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ic_valid_q <= '0;
        end else if (fill) begin
            ic_valid_q[mem_addr_q[IcacheIdxW+1:2]] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            ic_tag_q[mem_addr_q[IcacheIdxW+1:2]]  <= mem_addr_q[AddrLen-1:IcacheIdxW+2];
            ic_data_q[mem_addr_q[IcacheIdxW+1:2]] <= mem_inst_i;
        end
    end

    logic unused_fill_addr;
    assign unused_fill_addr = ^mem_addr_q[1:0];
`else
    assign hit      = 1'b0;
    assign hit_inst = ZeroWord;

    logic [31:0] unused_cfg;
    assign unused_cfg = IcacheIdxW;
`endif

    // ------------------------------------------------------------------ next-PC prediction
    assign avail    = (state_q == StIdle) && (buf_valid_q || hit);
    assign cur_inst = buf_valid_q ? buf_q : hit_inst;

    always_comb begin
        next_pc = pc_q + 32'd4;
        pred    = 1'b0;
        if (cur_inst[6:0] == OpJal) begin
            next_pc = pc_q + imm_j(cur_inst[31:12]);
            pred    = 1'b1;
        end else if ((cur_inst[6:0] == OpBranch) && bht_taken) begin
            next_pc = pc_q + imm_b(cur_inst[31:25], cur_inst[11:7]);
            pred    = 1'b1;
        end
    end

    // ------------------------------------------------------------------ FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else if (rdy_i) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------ FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (!failed_i && !avail) state_d = StWaitMem;
            StWaitMem: if (mem_done_i) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ datapath next state
    always_comb begin
        pc_d        = pc_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        discard_d   = discard_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (failed_i) begin
                    pc_d        = failed_pc_i;
                    buf_valid_d = 1'b0;
                end else if (avail) begin
                    if (!if_id_stall_i) begin
                        pc_d        = next_pc;
                        buf_valid_d = 1'b0;
                    end
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_q[AddrLen-1:2], 2'b00};
                end
            end
            StWaitMem: begin
                if (mem_done_i) begin
                    mem_req_d   = 1'b0;
                    buf_d       = mem_inst_i;
                    buf_valid_d = !discard_q && !failed_i;
                    discard_d   = 1'b0;
                    if (failed_i) pc_d = failed_pc_i;
                end else if (failed_i) begin
                    // Request stays in flight; its data may only fill the cache.
                    pc_d        = failed_pc_i;
                    buf_valid_d = 1'b0;
                    discard_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= ZeroWord;
            buf_q       <= ZeroWord;
            buf_valid_q <= 1'b0;
            discard_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= ZeroWord;
        end else if (rdy_i) begin
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            discard_q   <= discard_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // ------------------------------------------------------------------ FSM: outputs
    always_comb begin
        mem_req_o          = mem_req_q;
        mem_addr_o         = mem_addr_q;
        if_pc_o            = pc_q;
        if_inst_o          = avail ? cur_inst : ZeroWord;
        pred_jump_or_not_o = avail && pred;
        if_stall_o         = failed_i || !avail;
    end

endmodule
